// File: rtl/xdma_c2h_axis_rr_arbiter_pkg.sv
// Shared XDMA/UDP stream constants and arbiter state encoding.
// Imported by the C2H arbiter and its register slice.
package xdma_udp_pkg;

    localparam int XDMA_AXIS_TDATA_WIDTH = 512;
    localparam int XDMA_AXIS_TKEEP_WIDTH = XDMA_AXIS_TDATA_WIDTH / 8;
    localparam int XDMA_AXIS_TUSER_WIDTH = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/xdma_c2h_axis_rr_arbiter_skid.sv
// Two-entry AXI-Stream register slice (main + skid registers).
// The output is driven only from the main registers; ready is registered.
module axis_skid_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             push;
    logic             pop;

    assign in_ready  = !skid_valid;
    assign push      = in_valid && !skid_valid;
    assign pop       = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (pop) begin
            // A full skid blocks push, so it always refills main first
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (push) begin
                main_data <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (push) begin
            if (!main_valid) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/xdma_c2h_axis_rr_arbiter.sv
// Packet-level round-robin merge of two RX streams onto the XDMA C2H channel.
// Beats of different packets never interleave; output goes through a skid slice.
module xdma_c2h_axis_rr_arbiter
    import xdma_udp_pkg::*;
#(
    parameter int TDATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
    parameter int TKEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
    parameter int TUSER_WIDTH = XDMA_AXIS_TUSER_WIDTH
) (
    input  logic                   xdma_clk,
    input  logic                   xdma_reset,

    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s0_axis_tuser,
    input  logic                   s0_axis_tlast,

    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s1_axis_tuser,
    input  logic                   s1_axis_tlast,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,

    output logic                   grant_idx,
    output logic [31:0]            pkt_cnt0,
    output logic [31:0]            pkt_cnt1
);

    localparam int PW = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          grant_q;
    logic          grant_d;
    logic          rr_last_q;

    logic          sel_valid;
    logic          sel_last;
    logic [PW-1:0] sel_payload;
    logic          push_valid;
    logic          slice_ready;
    logic [PW-1:0] slice_out;
    logic          beat_acc;
    logic          pkt_done;

    assign sel_valid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = grant_q ? s1_axis_tlast : s0_axis_tlast;

    assign sel_payload = grant_q
        ? {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast}
        : {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast};

    assign beat_acc  = (state_q == ARB_BUSY) && sel_valid && slice_ready;
    assign pkt_done  = beat_acc && sel_last;
    assign grant_idx = grant_q;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        push_valid     = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // Tie goes to whoever did not finish the previous packet
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        grant_d = ~rr_last_q;
                    end else begin
                        grant_d = s1_axis_tvalid;
                    end
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                push_valid = sel_valid;
                if (grant_q) begin
                    s1_axis_tready = slice_ready;
                end else begin
                    s0_axis_tready = slice_ready;
                end
                if (pkt_done) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge xdma_clk or negedge xdma_reset) begin
        if (!xdma_reset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (pkt_done) begin
                rr_last_q <= grant_q;
            end
        end
    end

    always_ff @(posedge xdma_clk or negedge xdma_reset) begin
        if (!xdma_reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (pkt_done) begin
            if (grant_q) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end else begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
        end
    end

    axis_skid_slice #(
        .WIDTH (PW)
    ) u_slice (
        .clk       (xdma_clk),
        .rst_n     (xdma_reset),
        .in_valid  (push_valid),
        .in_ready  (slice_ready),
        .in_data   (sel_payload),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (slice_out)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = slice_out;

endmodule

// File: tb/tb_xdma_c2h_axis_rr_arbiter.sv
// Self-checking bench for the C2H round-robin arbiter.
// Expected output order comes from a packet-level round-robin model.
module tb_xdma_c2h_axis_rr_arbiter;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic [0:0]   u;
        logic         l;
    } pay_t;

    typedef struct {
        pay_t p;
        int   gap;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic         s0_axis_tvalid;
    logic         s0_axis_tready;
    logic [511:0] s0_axis_tdata;
    logic [63:0]  s0_axis_tkeep;
    logic [0:0]   s0_axis_tuser;
    logic         s0_axis_tlast;
    logic         s1_axis_tvalid;
    logic         s1_axis_tready;
    logic [511:0] s1_axis_tdata;
    logic [63:0]  s1_axis_tkeep;
    logic [0:0]   s1_axis_tuser;
    logic         s1_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [0:0]   m_axis_tuser;
    logic         m_axis_tlast;
    logic         grant_idx;
    logic [31:0]  pkt_cnt0;
    logic [31:0]  pkt_cnt1;

    int n_checks = 0;
    int n_fail = 0;

    beat_t q0[$];
    beat_t q1[$];
    pay_t  pk0[$];
    pay_t  pk1[$];
    int    len0[$];
    int    len1[$];
    pay_t  outq[$];
    pay_t  expq[$];

    bit          m_rr;
    logic [31:0] exp0;
    logic [31:0] exp1;
    int          rdy_mode;
    int          pat;
    int          stab_viol;
    int          s1_rdy_seen;
    bit          s1_last_acc;
    bit          prev_stall;
    pay_t        prev_p;

    xdma_c2h_axis_rr_arbiter dut (
        .xdma_clk       (clk),
        .xdma_reset     (rst_n),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tkeep  (s0_axis_tkeep),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tlast  (s0_axis_tlast),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tkeep  (s1_axis_tkeep),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tlast  (s1_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .grant_idx      (grant_idx),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source drivers, sink monitor and tready generator
    always @(posedge clk) begin
        if (rst_n) begin
            if (s0_axis_tvalid && s0_axis_tready && q0.size() > 0)
                void'(q0.pop_front());
            if (s1_axis_tvalid && s1_axis_tready && q1.size() > 0) begin
                if (s1_axis_tlast) s1_last_acc = 1'b1;
                void'(q1.pop_front());
            end
            if (prev_stall && (m_axis_tvalid !== 1'b1 ||
                {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== prev_p))
                stab_viol++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_p = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready)
                outq.push_back(prev_p);
            if (s1_axis_tready) s1_rdy_seen++;
        end else begin
            prev_stall = 1'b0;
        end
        #1;
        if (q0.size() > 0 && q0[0].gap > 0) begin
            q0[0].gap = q0[0].gap - 1;
            s0_axis_tvalid = 1'b0;
        end else if (q0.size() > 0) begin
            s0_axis_tvalid = 1'b1;
            {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = q0[0].p;
        end else begin
            s0_axis_tvalid = 1'b0;
        end
        if (q1.size() > 0 && q1[0].gap > 0) begin
            q1[0].gap = q1[0].gap - 1;
            s1_axis_tvalid = 1'b0;
        end else if (q1.size() > 0) begin
            s1_axis_tvalid = 1'b1;
            {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast} = q1[0].p;
        end else begin
            s1_axis_tvalid = 1'b0;
        end
        case (rdy_mode)
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: begin
                m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
                pat++;
            end
            default: m_axis_tready = 1'b1;
        endcase
    end

    task automatic clear_tb();
        q0.delete(); q1.delete(); pk0.delete(); pk1.delete();
        len0.delete(); len1.delete(); outq.delete(); expq.delete();
        m_rr = 1'b1; exp0 = '0; exp1 = '0; pat = 0;
        stab_viol = 0; s1_rdy_seen = 0; s1_last_acc = 1'b0;
    endtask

    task automatic do_reset(input int mode);
        rst_n = 1'b0;
        rdy_mode = mode;
        clear_tb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic add_beat(input int src, input logic [511:0] d,
                            input logic [63:0] k, input logic u,
                            input logic l, input int gap);
        beat_t b;
        b.p = '{d: d, k: k, u: u, l: l};
        b.gap = gap;
        if (src == 0) begin q0.push_back(b); pk0.push_back(b.p); end
        else begin q1.push_back(b); pk1.push_back(b.p); end
    endtask

    task automatic add_pkt(input int src, input int len, input int gapmax);
        logic [511:0] d;
        logic [63:0]  k;
        for (int b = 0; b < len; b++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            k = (b == len - 1) ? {$urandom, $urandom} | 64'h1 : '1;
            add_beat(src, d, k, 1'($urandom_range(0, 1)), b == len - 1,
                     (b > 0 && gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        end
        if (src == 0) len0.push_back(len); else len1.push_back(len);
    endtask

    // Whole packets leave in round-robin order among sources with work pending
    task automatic build_expected();
        bit g;
        int n;
        while (len0.size() > 0 || len1.size() > 0) begin
            if (len0.size() > 0 && len1.size() > 0) g = ~m_rr;
            else g = (len0.size() == 0);
            n = g ? len1.pop_front() : len0.pop_front();
            repeat (n) expq.push_back(g ? pk1.pop_front() : pk0.pop_front());
            m_rr = g;
            if (g) exp1 = exp1 + 32'd1; else exp0 = exp0 + 32'd1;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (outq.size() >= expq.size() && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    function automatic int first_diff();
        int n;
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (outq[i] !== expq[i]) return i;
        if (outq.size() != expq.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rdy_mode = 0;
        clear_tb();
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got=%b want=0", m_axis_tvalid); end
        n_checks++;
        if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata got=%h want=0", m_axis_tdata[63:0]); end
        n_checks++;
        if (m_axis_tkeep !== '0) begin n_fail++; $display("FAIL rst_tkeep got=%h want=0", m_axis_tkeep); end
        n_checks++;
        if ({m_axis_tuser, m_axis_tlast} !== 2'b00) begin n_fail++; $display("FAIL rst_tuser_tlast got=%b want=00", {m_axis_tuser, m_axis_tlast}); end
        n_checks++;
        if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin n_fail++; $display("FAIL rst_tready got=%b want=00", {s0_axis_tready, s1_axis_tready}); end
        n_checks++;
        if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b want=0", grant_idx); end
        n_checks++;
        if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", pkt_cnt0, pkt_cnt1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int d;
        do_reset(0);
        add_beat(0, 512'hA0, '1, 1'b0, 1'b0, 0);
        add_beat(0, 512'hA1, '1, 1'b0, 1'b0, 0);
        add_beat(0, 512'hA2, 64'h0000_0000_0000_00FF, 1'b0, 1'b1, 0);
        len0.push_back(3);
        build_expected();
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL single_order beat=%0d got_beats=%0d want_beats=%0d", d, outq.size(), expq.size()); end
        n_checks++;
        if (pkt_cnt0 !== exp0 || pkt_cnt1 !== exp1) begin n_fail++; $display("FAIL single_cnt got=%0d/%0d want=%0d/%0d", pkt_cnt0, pkt_cnt1, exp0, exp1); end
        n_checks++;
        if (s1_rdy_seen != 0) begin n_fail++; $display("FAIL single_s1_tready got=%0d want=0 cycles", s1_rdy_seen); end
    endtask

    task automatic test_rr();
        bit ok;
        int d;
        do_reset(0);
        for (int r = 0; r < 4; r++) begin
            add_pkt(0, 2, 0);
            add_pkt(1, 2, 0);
        end
        build_expected();
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL rr_order beat=%0d got=%h want=%h", d, (d < outq.size()) ? outq[d].d[63:0] : 64'h0, (d < expq.size()) ? expq[d].d[63:0] : 64'h0); end
        n_checks++;
        if (pkt_cnt0 !== 32'd4 || pkt_cnt1 !== 32'd4) begin n_fail++; $display("FAIL rr_cnt got=%0d/%0d want=4/4", pkt_cnt0, pkt_cnt1); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int d;
        do_reset(2);
        add_pkt(0, 16, 0);
        build_expected();
        wait_done(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL bp_order beat=%0d got_beats=%0d want_beats=%0d", d, outq.size(), expq.size()); end
        n_checks++;
        if (stab_viol != 0) begin n_fail++; $display("FAIL bp_stable got=%0d want=0 violations", stab_viol); end
        n_checks++;
        if (pkt_cnt0 !== exp0) begin n_fail++; $display("FAIL bp_cnt got=%0d want=%0d", pkt_cnt0, exp0); end
    endtask

    task automatic test_stall();
        bit ok;
        int d;
        int viol;
        viol = 0;
        do_reset(0);
        add_pkt(1, 4, 0);
        q1[2].gap = 5;
        build_expected();
        repeat (2) @(negedge clk);
        add_pkt(0, 3, 0);
        build_expected();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s0_axis_tready && !s1_last_acc) viol++;
            if (outq.size() >= expq.size() && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL stall_holdoff got=%0d want=0 cycles", viol); end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL stall_order beat=%0d got_beats=%0d want_beats=%0d", d, outq.size(), expq.size()); end
        n_checks++;
        if (pkt_cnt0 !== exp0 || pkt_cnt1 !== exp1) begin n_fail++; $display("FAIL stall_cnt got=%0d/%0d want=%0d/%0d", pkt_cnt0, pkt_cnt1, exp0, exp1); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int d;
        do_reset(0);
        add_pkt(0, 4, 0);
        add_pkt(1, 1, 0);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (outq.size() >= 1 && m_axis_tvalid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rmid_reach got=%0d want=1 beats", outq.size()); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid got=%b want=0", m_axis_tvalid); end
        n_checks++;
        if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin n_fail++; $display("FAIL rmid_cnt got=%0d/%0d want=0/0", pkt_cnt0, pkt_cnt1); end
        n_checks++;
        if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin n_fail++; $display("FAIL rmid_tready got=%b want=00", {s0_axis_tready, s1_axis_tready}); end
        clear_tb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_pkt(1, 3, 0);
        add_pkt(0, 2, 0);
        build_expected();
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rmid_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL rmid_order beat=%0d got_beats=%0d want_beats=%0d", d, outq.size(), expq.size()); end
        n_checks++;
        if (pkt_cnt0 !== exp0 || pkt_cnt1 !== exp1) begin n_fail++; $display("FAIL rmid_cnt2 got=%0d/%0d want=%0d/%0d", pkt_cnt0, pkt_cnt1, exp0, exp1); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(0);
        force dut.pkt_cnt0 = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_cnt0;
        exp0 = 32'hFFFF_FFFF;
        add_pkt(0, 2, 0);
        build_expected();
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        n_checks++;
        if (pkt_cnt0 !== exp0) begin n_fail++; $display("FAIL wrap_cnt0 got=%h want=%h", pkt_cnt0, exp0); end
        n_checks++;
        if (pkt_cnt1 !== exp1) begin n_fail++; $display("FAIL wrap_cnt1 got=%h want=%h", pkt_cnt1, exp1); end
    endtask

    task automatic test_random();
        bit ok;
        int d;
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            add_pkt(0, $urandom_range(1, 8), 3);
            add_pkt(1, $urandom_range(1, 8), 3);
        end
        add_pkt(0, $urandom_range(1, 8), 2);
        add_pkt(0, $urandom_range(1, 8), 2);
        build_expected();
        wait_done(2000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rand_timeout got=%0d want=%0d beats", outq.size(), expq.size()); end
        d = first_diff();
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL rand_order beat=%0d got_beats=%0d want_beats=%0d", d, outq.size(), expq.size()); end
        n_checks++;
        if (stab_viol != 0) begin n_fail++; $display("FAIL rand_stable got=%0d want=0 violations", stab_viol); end
        n_checks++;
        if (pkt_cnt0 !== exp0 || pkt_cnt1 !== exp1) begin n_fail++; $display("FAIL rand_cnt got=%0d/%0d want=%0d/%0d", pkt_cnt0, pkt_cnt1, exp0, exp1); end
    endtask

    initial begin
        rst_n = 1'b0;
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        s0_axis_tvalid = 1'b0;
        s1_axis_tvalid = 1'b0;
        s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
        s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
        clear_tb();
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
